ula_sequenciador_multibyte: RTL and testbench

// Byte-serial sequencer that sits directly in front of ula_8_bits. It runs an
// N_BYTES*8-bit operation through the 8-bit ALU one byte per cycle, LSB first,

---
 rtl/ula_sequenciador_multibyte.sv | 156 +++++++++++++++
 tb/tb_ula_sequenciador_multibyte.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador_multibyte.sv
// ula_sequenciador_multibyte
// Byte-serial front end for ula_8_bits. A W = 8*N_BYTES bit operation is
// pushed through the 8-bit ALU one byte per cycle, LSB first, with the ALU
// carry-out of each byte fed back as the carry-in of the next. Result bytes,
// the final carry and the AND of the per-byte a_eq_b flags are collected and
// offered downstream through a valid/ready handshake.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           request handshake (accepted only in IDLE)
//   op_a, op_b [W]              operands
//   op_s [4], op_m, op_c_in     ALU function, mode (1 = logic), carry into byte 0
//   alu_a/alu_b/alu_s/alu_m/alu_c_in   drive ula_8_bits
//   alu_f, alu_c_out, alu_a_eq_b       results from ula_8_bits
//   out_valid/out_ready         result handshake
//   res_f [W], res_c_out, res_a_eq_b   assembled result bundle
//   busy                        sequencer not idle
module ula_sequenciador_multibyte #(
  parameter int N_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*N_BYTES-1:0]   op_a,
  input  logic [8*N_BYTES-1:0]   op_b,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_c_in,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_c_in,
  input  logic [7:0]             alu_f,
  input  logic                   alu_c_out,
  input  logic                   alu_a_eq_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_BYTES-1:0]   res_f,
  output logic                   res_c_out,
  output logic                   res_a_eq_b,
  output logic                   busy
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [N_BYTES-1:0][7:0]     a_q, a_d;
  logic [N_BYTES-1:0][7:0]     b_q, b_d;
  logic [3:0]                  s_q, s_d;
  logic                        m_q, m_d;
  logic                        cin_q, cin_d;
  logic                        carry_q, carry_d;
  logic                        eq_q, eq_d;
  logic [N_BYTES-1:0][7:0]     res_f_q, res_f_d;
  logic                        res_c_q, res_c_d;

  logic exec;
  assign exec = (state_q == S_EXEC);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    res_f_d = res_f_q;
    res_c_d = res_c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          cin_d   = op_c_in;
          idx_d   = '0;
          eq_d    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_f_d[idx_q] = alu_f;
        carry_d        = alu_c_out;
        eq_d           = eq_q & alu_a_eq_b;
        if (idx_q == LAST_IDX) begin
          res_c_d = alu_c_out;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        // Returning to IDLE takes its own edge, so no request is taken here.
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      res_f_q <= '0;
      res_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      res_f_q <= res_f_d;
      res_c_q <= res_c_d;
    end
  end

  // ALU operands are only live during EXEC; S/M stay parked at the last op.
  assign alu_a    = exec ? a_q[idx_q] : 8'h00;
  assign alu_b    = exec ? b_q[idx_q] : 8'h00;
  assign alu_s    = s_q;
  assign alu_m    = m_q;
  // Byte 0 takes the request carry, later bytes the previous byte's carry-out.
  assign alu_c_in = exec & ((idx_q == '0) ? cin_q : carry_q);

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign res_f      = res_f_q;
  assign res_c_out  = res_c_q;
  assign res_a_eq_b = eq_q;

endmodule

// File: tb/tb_ula_sequenciador_multibyte.sv
module tb_ula_sequenciador_multibyte;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic [3:0] op_s;
  logic op_m, op_c_in;
  logic [7:0] alu_a, alu_b, alu_f;
  logic [3:0] alu_s;
  logic alu_m, alu_c_in, alu_c_out, alu_a_eq_b;
  logic out_valid, out_ready;
  logic [W-1:0] res_f;
  logic res_c_out, res_a_eq_b, busy;

  always #5 clk = ~clk;

  ula_sequenciador_multibyte #(.N_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_c_in(op_c_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_f(res_f), .res_c_out(res_c_out), .res_a_eq_b(res_a_eq_b), .busy(busy)
  );

  // Stand-in for ula_8_bits (active-high data, active-high carry):
  // arithmetic S=1001 A plus B, S=0110 A minus B minus 1 (+carry);
  // logic S=0110 XOR, S=0000 NOT A; A=B flag is "F all ones".
  always_comb begin
    alu_f     = 8'h00;
    alu_c_out = 1'b0;
    if (alu_m) begin
      case (alu_s)
        4'b0110: alu_f = alu_a ^ alu_b;
        4'b0000: alu_f = ~alu_a;
        default: alu_f = alu_a & alu_b;
      endcase
    end else begin
      case (alu_s)
        4'b1001: {alu_c_out, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c_in};
        4'b0110: {alu_c_out, alu_f} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_c_in};
        default: {alu_c_out, alu_f} = {1'b0, alu_a} + {8'h00, alu_c_in};
      endcase
    end
    alu_a_eq_b = &alu_f;
  end

  typedef struct packed {
    logic [W-1:0] f;
    logic         c;
    logic         eq;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Whole-word reference: a W-bit operation done in one step.
  function automatic exp_t ref_op(logic [W-1:0] a, logic [W-1:0] b,
                                  logic [3:0] s, logic m, logic cin);
    exp_t e;
    logic [W:0] sum;
    e   = '0;
    sum = '0;
    if (m) begin
      case (s)
        4'b0110: e.f = a ^ b;
        4'b0000: e.f = ~a;
        default: e.f = a & b;
      endcase
      e.c = 1'b0;
    end else begin
      case (s)
        4'b1001: sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
        default: sum = {1'b0, a} + {{W{1'b0}}, cin};
      endcase
      e.f = sum[W-1:0];
      e.c = sum[W];
    end
    e.eq = &e.f;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called #1 after a rising edge. Accepts one request, then scrambles op_*.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic cin);
    op_a = a; op_b = b; op_s = s; op_m = m; op_c_in = cin;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ref_op(a, b, s, m, cin));
    op_a = W'($urandom); op_b = W'($urandom); op_c_in = ~cin;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Waits for the result, checks latency and bundle. Leaves the DUT in DONE
  // when out_ready is 0, otherwise steps it back to IDLE and checks that.
  task automatic finish_op(input string name);
    int lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(NB));
    chk({name, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_res_f"}, 64'(res_f), 64'(e.f));
      chk({name, "_res_c_out"}, 64'(res_c_out), 64'(e.c));
      chk({name, "_res_a_eq_b"}, 64'(res_a_eq_b), 64'(e.eq));
    end
    chk({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
    chk({name, "_alu_idle_done"}, {55'd0, alu_c_in, alu_a}, 64'd0);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({name, "_back_idle"}, {62'd0, out_valid, in_ready}, 64'd1);
    end
  endtask

  initial begin
    logic [W-1:0] held_f;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_c_in = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_res", {31'd0, res_c_out, res_a_eq_b, res_f}, 64'd0);
    chk("rst_alu", {55'd0, alu_c_in, alu_a}, 64'd0);

    // 1. add with carry across byte 0
    start_op(32'h0000_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
    finish_op("t1_add");
    // 2. carry ripples through every byte
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
    finish_op("t2_ripple");
    // 3. equality via A minus B minus 1
    start_op(32'h1234_5678, 32'h1234_5678, 4'b0110, 1'b0, 1'b0);
    finish_op("t3_eq");
    start_op(32'h1234_5678, 32'h1234_5679, 4'b0110, 1'b0, 1'b0);
    finish_op("t3_neq");
    // 4. logic XOR
    start_op(32'hAAAA_5555, 32'h5555_AAAA, 4'b0110, 1'b1, 1'b0);
    finish_op("t4_xor");
    // carry-in on byte 0 and a few random words
    start_op(32'h0000_FFFF, 32'h0000_0000, 4'b1001, 1'b0, 1'b1);
    finish_op("cin_add");
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      start_op(ra, rb, (i % 2 == 0) ? 4'b1001 : 4'b0110, 1'b0, 1'(i / 2));
      finish_op("rand");
    end

    // 5. stall in DONE with in_valid asserted
    out_ready = 1'b0;
    start_op(32'h0102_0304, 32'h1010_1010, 4'b1001, 1'b0, 1'b0);
    finish_op("t5_hold");
    held_f = res_f;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      @(posedge clk); #1;
      chk("t5_out_valid_held", 64'(out_valid), 64'd1);
      chk("t5_in_ready_low", 64'(in_ready), 64'd0);
      chk("t5_res_stable", 64'(res_f), 64'(held_f));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_accept_on_exit", {62'd0, busy, out_valid}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_still_idle", 64'(busy), 64'd0);

    // 6. reset while idx = 2
    start_op(32'h0000_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_res_f", 64'(res_f), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle_after_rst", {62'd0, busy, out_valid}, 64'd0);
    start_op(32'h0000_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
    finish_op("t6_rerun");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
